execute_muldiv_unit: RTL and testbench
======================================

Name: execute_muldiv_unit

Overview:
Iterative RV64M multiply/divide unit placed in the execute stage beside the single-cycle ALU. It accepts one M-extension op per request from the decoded EX-stage controls and holds the pipeline via a stall output while it iterates. It returns the result plus rd address for the EX/MEM register. Supports full-width ops and the 32-bit *W variants.

Parameters:
DATA_WIDTH, 64, operand/result width.
WORD_WIDTH, 32, width of *W ops; results sign-extended to DATA_WIDTH.
REG_ADDR_W, 5, destination register address width.

Ports:
clk_i  in  1  clock.
arst_i  in  1  asynchronous, active-high reset.
start_i  in  1  valid M-extension op present in EX.
flush_i  in  1  kill in-flight op (mispredict/trap).
func3_i  in  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
word_i  in  1  *W variant (mulw/divw/divuw/remw/remuw).
rs1_data_i  in  DATA_WIDTH  forwarded operand A.
rs2_data_i  in  DATA_WIDTH  forwarded operand B.
rd_addr_i  in  REG_ADDR_W  destination register.
stall_o  out  1  hold IF/ID/EX; combinational.
done_o  out  1  one-cycle result-valid pulse.
result_o  out  DATA_WIDTH  registered result.
rd_addr_o  out  REG_ADDR_W  latched destination.

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset (arst_i high, async) -> IDLE; result_o=0, rd_addr_o=0, done_o=0, stall_o=0, counter and shift registers 0.
- Accept: IDLE & start_i & !flush_i latches operands, func3, word, rd. Operands are reduced to magnitude plus sign flags; word ops use the low WORD_WIDTH bits, sign- or zero-extended per op. Transition to MUL (func3<4) or DIV.
- stall_o = (IDLE & start_i & !flush_i) | MUL | DIV. stall_o is 0 in DONE, which lets the pipeline advance that cycle.
- MUL: shift-add, 1 multiplier bit per cycle, 2*DATA_WIDTH accumulator. Iteration count N = DATA_WIDTH, or WORD_WIDTH if word.
- DIV: restoring, 1 quotient bit per cycle, N iterations.
- Latency: accept at cycle T; iterations T+1..T+N; DONE at T+N+1 with done_o=1 and result_o valid. DONE always returns to IDLE. start_i is ignored in DONE, because the same instruction is still in EX.
- Sign fix is applied when registering the final result:
  - mul returns the low half.
  - mulh/mulhsu/mulhu return the high half of the signed/signed-unsigned/unsigned product.
  - Quotient is negated if the operand signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Word results are sign-extended from bit WORD_WIDTH-1.
- Divide by zero (divisor, or its low word for word ops, is 0): DIV skips iteration, DONE at T+1. Quotient = all ones; remainder = dividend (sign-extended for word ops).
- Signed overflow (most-negative / -1): DONE at T+1; quotient = dividend, remainder = 0.
- flush_i in any state: next state IDLE, no done_o, counter cleared, stall_o forced 0 that cycle. flush_i with start_i in IDLE: the op is not accepted.
- Reset mid-operation: immediate IDLE; no done_o.

Optional Feature:
Macro MDU_EARLY_OUT_EN.
- Defined: MUL exits to DONE as soon as the remaining multiplier shift register is zero, giving variable latency (minimum T+1 for a zero multiplier).
- Not defined: fixed N-iteration multiply.
- Division latency is unaffected in both cases. Results are identical in both cases.

Decomposition:
- Package execute_muldiv_pkg holds:
  - state enum;
  - func3 op localparams (OP_MUL..OP_REMU);
  - counter width localparam $clog2(DATA_WIDTH)+1.
- One sub-module, mdu_operand_prep (combinational). It performs word selection/extension, absolute values, sign flags, and divide-by-zero/overflow detection.
- The FSM and datapath stay in execute_muldiv_unit.

Test Plan:
1. mul 7 * 0xFFFF_FFFF_FFFF_FFFD -> result 0xFFFF_FFFF_FFFF_FFEB. done_o at T+65; stall_o high T..T+64, low at T+65.
2. mulhu 0xFFFF_FFFF_FFFF_FFFF squared -> 0xFFFF_FFFF_FFFF_FFFE. mulh of the same operands -> 0.
3. div 0xFFFF_FFFF_FFFF_FFF9 / 2 -> 0xFFFF_FFFF_FFFF_FFFD. rem of the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
4. divu 123 / 0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1. div 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 at T+1; rem of the same -> 0.
5. Word ops:
   - mulw 0x7FFF_FFFF * 2 -> 0xFFFF_FFFF_FFFF_FFFE at T+33.
   - divw 0x1_0000_0007 / 2 -> 3.
6. Flush and reset:
   - flush_i at T+10 of a div -> no done_o; IDLE at T+11.
   - start_i held in DONE -> no second op.
   - arst_i mid-mul -> outputs 0.

Source files
------------

// File: rtl/execute_muldiv_pkg.sv
// execute_muldiv_pkg: shared state encoding, M-extension op codes and counter sizing for the MDU.
package execute_muldiv_pkg;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} mdu_state_e;
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;
    localparam int MDU_DATA_WIDTH = 64;
    localparam int CNT_W = $clog2(MDU_DATA_WIDTH) + 1;
endpackage

// File: rtl/mdu_operand_prep.sv
// mdu_operand_prep: word selection/extension, magnitudes, sign flags and divide special-case detection.
module mdu_operand_prep
    import execute_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int WORD_WIDTH = 32
) (
    input  logic [2:0]            func3_i,
    input  logic                  word_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] a_ext_o,
    output logic [DATA_WIDTH-1:0] a_mag_o,
    output logic [DATA_WIDTH-1:0] b_mag_o,
    output logic                  a_neg_o,
    output logic                  b_neg_o,
    output logic                  div_zero_o,
    output logic                  div_ovf_o
);
    localparam int EXT_W = DATA_WIDTH - WORD_WIDTH;
    logic                  a_sgn, b_sgn;
    logic [DATA_WIDTH-1:0] b_ext, min_neg;
    always_comb begin
        a_sgn      = func3_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_sgn      = func3_i inside {OP_MULH, OP_DIV, OP_REM};
        a_ext_o    = word_i ? {{EXT_W{a_sgn & a_i[WORD_WIDTH-1]}}, a_i[WORD_WIDTH-1:0]} : a_i;
        b_ext      = word_i ? {{EXT_W{b_sgn & b_i[WORD_WIDTH-1]}}, b_i[WORD_WIDTH-1:0]} : b_i;
        a_neg_o    = a_sgn & a_ext_o[DATA_WIDTH-1];
        b_neg_o    = b_sgn & b_ext[DATA_WIDTH-1];
        a_mag_o    = a_neg_o ? -a_ext_o : a_ext_o;
        b_mag_o    = b_neg_o ? -b_ext : b_ext;
        min_neg    = word_i ? {{(EXT_W + 1){1'b1}}, {(WORD_WIDTH - 1){1'b0}}} : {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        div_zero_o = (b_ext == '0);
        div_ovf_o  = b_sgn & (a_ext_o == min_neg) & (&b_ext);
    end
endmodule

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: iterative RV64M shift-add multiplier / restoring divider for the EX stage.
// Define MDU_EARLY_OUT_EN to end multiplies as soon as the remaining multiplier bits are zero.
module execute_muldiv_unit
    import execute_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int WORD_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [2:0]            func3_i,
    input  logic                  word_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o
);
    localparam int EXT_W = DATA_WIDTH - WORD_WIDTH;
    mdu_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_last;
    logic [2*DATA_WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d, prod_nxt, prod_s;
    logic [DATA_WIDTH-1:0]   opb_q, opb_d, quo_q, quo_d, rem_q, rem_d, result_q, result_d;
    logic [DATA_WIDTH-1:0]   quo_nxt, rem_nxt, q_s, r_s, res_raw, res_fix, spec_raw, spec_fix;
    logic [DATA_WIDTH-1:0]   a_ext, a_mag, b_mag;
    logic [DATA_WIDTH:0]     rem_sh, rem_sub;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic [2:0]              func3_q, func3_d;
    logic word_q, word_d, neg_q, neg_d, rneg_q, rneg_d;
    logic a_neg, b_neg, div_zero, div_ovf, accept, mul_exit, mul_zero;

    mdu_operand_prep #(.DATA_WIDTH(DATA_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_prep (
        .func3_i   (func3_i),
        .word_i    (word_i),
        .a_i       (rs1_data_i),
        .b_i       (rs2_data_i),
        .a_ext_o   (a_ext),
        .a_mag_o   (a_mag),
        .b_mag_o   (b_mag),
        .a_neg_o   (a_neg),
        .b_neg_o   (b_neg),
        .div_zero_o(div_zero),
        .div_ovf_o (div_ovf)
    );

    assign accept    = (state_q == S_IDLE) & start_i & ~flush_i;
    assign stall_o   = ~flush_i & (accept | (state_q == S_MUL) | (state_q == S_DIV));
    assign done_o    = (state_q == S_DONE);
    assign result_o  = result_q;
    assign rd_addr_o = rd_q;

`ifdef MDU_EARLY_OUT_EN
    assign mul_zero = (b_mag == '0);
    assign mul_exit = (cnt_q == cnt_last) | (opb_q[DATA_WIDTH-1:1] == '0);
`else
    assign mul_zero = 1'b0;
    assign mul_exit = (cnt_q == cnt_last);
`endif

    // Datapath for one iteration plus the sign fix applied to whatever the final step produces.
    always_comb begin
        cnt_last = word_q ? CNT_W'(WORD_WIDTH - 1) : CNT_W'(DATA_WIDTH - 1);
        prod_nxt = prod_q + (opb_q[0] ? mcand_q : '0);
        rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, opb_q};
        quo_nxt  = {quo_q[DATA_WIDTH-2:0], ~rem_sub[DATA_WIDTH]};
        rem_nxt  = rem_sub[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : rem_sub[DATA_WIDTH-1:0];
        prod_s   = neg_q ? -prod_nxt : prod_nxt;
        q_s      = neg_q ? -quo_nxt : quo_nxt;
        r_s      = rneg_q ? -rem_nxt : rem_nxt;
        res_raw  = (state_q == S_MUL) ? ((func3_q == OP_MUL) ? prod_s[DATA_WIDTH-1:0] : prod_s[2*DATA_WIDTH-1:DATA_WIDTH])
                                      : (func3_q[1] ? r_s : q_s);
        res_fix  = word_q ? {{EXT_W{res_raw[WORD_WIDTH-1]}}, res_raw[WORD_WIDTH-1:0]} : res_raw;
        spec_raw = div_ovf ? (func3_i[1] ? '0 : a_ext) : (func3_i[1] ? a_ext : '1);
        spec_fix = word_i ? {{EXT_W{spec_raw[WORD_WIDTH-1]}}, spec_raw[WORD_WIDTH-1:0]} : spec_raw;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;
        rd_d     = rd_q;
        func3_d  = func3_q;
        word_d   = word_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            func3_d = func3_i;
            word_d  = word_i;
            rd_d    = rd_addr_i;
            cnt_d   = '0;
            prod_d  = '0;
            mcand_d = {{DATA_WIDTH{1'b0}}, a_mag};
            opb_d   = b_mag;
            quo_d   = word_i ? a_mag << WORD_WIDTH : a_mag;
            rem_d   = '0;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            if (func3_i[2] & (div_zero | div_ovf)) begin
                state_d  = S_DONE;
                result_d = spec_fix;
            end else if (func3_i[2]) begin
                state_d = S_DIV;
            end else if (mul_zero) begin
                state_d  = S_DONE;
                result_d = '0;
            end else begin
                state_d = S_MUL;
            end
        end else if (state_q == S_MUL) begin
            prod_d  = prod_nxt;
            mcand_d = mcand_q << 1;
            opb_d   = opb_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (mul_exit) begin
                state_d  = S_DONE;
                result_d = res_fix;
                cnt_d    = '0;
            end
        end else if (state_q == S_DIV) begin
            quo_d = quo_nxt;
            rem_d = rem_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == cnt_last) begin
                state_d  = S_DONE;
                result_d = res_fix;
                cnt_d    = '0;
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            func3_q  <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            func3_q  <= func3_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
        end
    end
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: directed vector table, flush/reset/hold sequences and random ops vs. an arithmetic model.
module tb_execute_muldiv_unit;
    logic        clk_i = 1'b0, arst_i = 1'b1, start_i = 1'b0, flush_i = 1'b0, word_i = 1'b0;
    logic [2:0]  func3_i = 3'd0;
    logic [63:0] rs1_data_i = '0, rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        stall_o, done_o;
    logic [63:0] result_o;
    logic [4:0]  rd_addr_o;
    int checks = 0, errors = 0;

    always #5 clk_i = ~clk_i;

    execute_muldiv_unit dut (
        .clk_i(clk_i), .arst_i(arst_i), .start_i(start_i), .flush_i(flush_i),
        .func3_i(func3_i), .word_i(word_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rd_addr_i(rd_addr_i), .stall_o(stall_o), .done_o(done_o), .result_o(result_o),
        .rd_addr_o(rd_addr_o)
    );

    typedef struct packed {
        logic [2:0]  f;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs [18];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // RISC-V M semantics from plain integer arithmetic.
    function automatic logic [63:0] ref_res(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  r32;
        int           sa32, sb32;
        longint       sa, sb;
        sa32 = int'(a[31:0]);
        sb32 = int'(b[31:0]);
        sa   = longint'(a);
        sb   = longint'(b);
        if (w) begin
            if (f == 3'd0) r32 = a[31:0] * b[31:0];
            else if (b[31:0] == 32'h0) r32 = f[1] ? a[31:0] : 32'hFFFF_FFFF;
            else if (f == 3'd5) r32 = a[31:0] / b[31:0];
            else if (f == 3'd7) r32 = a[31:0] % b[31:0];
            else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = f[1] ? 32'h0 : a[31:0];
            else r32 = f[1] ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
            return {{32{r32[31]}}, r32};
        end
        if (f == 3'd0) return a * b;
        if (!f[2]) begin
            p = {{64{(f != 3'd3) && a[63]}}, a} * {{64{(f == 3'd1) && b[63]}}, b};
            return p[127:64];
        end
        if (b == 64'h0) return f[1] ? a : '1;
        if (f == 3'd5) return a / b;
        if (f == 3'd7) return a % b;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return f[1] ? 64'h0 : a;
        return f[1] ? 64'(sa % sb) : 64'(sa / sb);
    endfunction

    // Cycles from the accept cycle to the done_o cycle.
    function automatic int ref_lat(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
        int          n;
        logic [63:0] bw;
        n  = w ? 32 : 64;
        bw = w ? {32'h0, b[31:0]} : b;
        if (f[2]) begin
            if (bw == 64'h0) return 1;
            if ((f == 3'd4 || f == 3'd6) && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                               : (a == 64'h8000_0000_0000_0000 && b == '1))) return 1;
            return n + 1;
        end
`ifdef MDU_EARLY_OUT_EN
        begin
            logic [63:0] m;
            int          k;
            m = (f == 3'd1 && b[63]) ? -b : bw;
            k = 0;
            while (m != 64'h0) begin
                m = m >> 1;
                k++;
            end
            return (k == 0) ? 1 : k + 1;
        end
`else
        return n + 1;
`endif
    endfunction

    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic [63:0] exp, input bit hold, input string tag);
        int n, lat, bad;
        lat = ref_lat(f, w, a, b);
        @(negedge clk_i);
        flush_i = 1'b0; start_i = 1'b1; func3_i = f; word_i = w;
        rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
        #1 check({tag, "_stall_accept"}, 64'(stall_o), 64'd1);
        n = 0;
        bad = 0;
        do begin
            @(negedge clk_i);
            #1;
            n++;
            if (!done_o && !stall_o) bad++;
        end while (!done_o && n < 200);
        check({tag, "_done"}, 64'(done_o), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_stall_done"}, 64'(stall_o), 64'd0);
        check({tag, "_stall_busy"}, 64'(bad), 64'd0);
        check({tag, "_result"}, result_o, exp);
        check({tag, "_rd"}, 64'(rd_addr_o), 64'(rd));
        if (!hold) start_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        #1 check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    endtask

    function automatic logic [63:0] rnd_operand();
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel == 0) return 64'h0;
        if (sel == 1) return '1;
        if (sel == 2) return 64'h8000_0000_0000_0000;
        if (sel == 3) return 64'($urandom_range(0, 20));
        if (sel == 4) return {32'h0, $urandom};
        return {$urandom, $urandom};
    endfunction

    initial begin
        int bad;
        vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[3]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[4]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5]  = '{3'd5, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        vecs[7]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[8]  = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[9]  = '{3'd4, 1'b1, 64'h1_0000_0007, 64'd2, 64'd3};
        vecs[10] = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[11] = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2};
        vecs[12] = '{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[13] = '{3'd7, 1'b1, 64'd5, 64'd0, 64'd5};
        vecs[14] = '{3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0};
        vecs[15] = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
        vecs[16] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[17] = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

        repeat (2) @(negedge clk_i);
        #1;
        check("reset_result", result_o, 64'h0);
        check("reset_rd", 64'(rd_addr_o), 64'h0);
        check("reset_done", 64'(done_o), 64'h0);
        check("reset_stall", 64'(stall_o), 64'h0);
        arst_i = 1'b0;

        for (int i = 0; i < 18; i++)
            run_op(vecs[i].f, vecs[i].w, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, 1'b0, $sformatf("vec%0d", i));

        run_op(3'd0, 1'b0, 64'd3, 64'd5, 5'd4, 64'd15, 1'b1, "hold");
        bad = 0;
        repeat (70) begin
            @(negedge clk_i);
            #1;
            if (done_o || stall_o) bad++;
        end
        check("hold_no_second_op", 64'(bad), 64'd0);

        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; func3_i = 3'd4; word_i = 1'b0;
        rs1_data_i = 64'd100; rs2_data_i = 64'd3; rd_addr_i = 5'd6;
        #1 check("flush_idle_stall", 64'(stall_o), 64'd0);
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        #1 check("flush_idle_not_accepted", 64'(stall_o), 64'd0);

        @(negedge clk_i);
        start_i = 1'b1; func3_i = 3'd4; word_i = 1'b0;
        rs1_data_i = 64'd1000; rs2_data_i = 64'd7; rd_addr_i = 5'd9;
        repeat (10) @(negedge clk_i);
        flush_i = 1'b1; start_i = 1'b0;
        #1 check("flush_div_stall", 64'(stall_o), 64'd0);
        run_op(3'd5, 1'b0, 64'd1000, 64'd7, 5'd11, 64'd142, 1'b0, "post_flush");

        @(negedge clk_i);
        start_i = 1'b1; func3_i = 3'd0; word_i = 1'b0;
        rs1_data_i = 64'd12345; rs2_data_i = 64'd6789; rd_addr_i = 5'd17;
        repeat (20) @(negedge clk_i);
        #2 arst_i = 1'b1;
        start_i = 1'b0;
        #1;
        check("arst_result", result_o, 64'h0);
        check("arst_rd", 64'(rd_addr_o), 64'h0);
        check("arst_done", 64'(done_o), 64'h0);
        check("arst_stall", 64'(stall_o), 64'h0);
        @(negedge clk_i);
        arst_i = 1'b0;
        run_op(3'd0, 1'b0, 64'd12345, 64'd6789, 5'd17, 64'd83810205, 1'b0, "post_arst");

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic        w;
            logic [63:0] a, b;
            f = 3'($urandom_range(0, 7));
            w = ($urandom_range(0, 1) == 1) && (f == 3'd0 || f[2]);
            a = rnd_operand();
            b = rnd_operand();
            run_op(f, w, a, b, 5'($urandom_range(0, 31)), ref_res(f, w, a, b), 1'b0, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
